fetch_sequencer: RTL
====================

# fetch_sequencer

Fetch controller that owns the program counter register and sequences instruction fetch for the single-cycle core. Each cycle it either holds the PC, advances it by 4, or redirects it to a taken CBZ target computed as PC + (SignExt << 2). It issues one outstanding request at a time to instruction memory over a request/grant handshake, and presents the returned instruction to decode over a valid/ready handshake. It discards any fetch made stale by a redirect.

## Interface
- ADDR_W, 64, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-low reset
- Halt  in  1  suppresses new fetches; sampled only at the IDLE and HOLD exits
- IMemReq  out  1  fetch request
- IMemAddr  out  ADDR_W  fetch address (current PC)
- IMemGnt  in  1  request accepted this cycle
- IMemRspValid  in  1  response data valid
- IMemRspData  in  INSTR_W  fetched instruction
- InstrValid  out  1  instruction available to decode
- Instr  out  INSTR_W  held instruction
- InstrPC  out  ADDR_W  address of Instr
- InstrReady  in  1  decode accepts Instr this cycle
- BrValid  in  1  branch resolution valid this cycle
- Branch  in  1  instruction is CBZ
- ALUZero  in  1  compare result zero
- BranchPC  in  ADDR_W  PC of the resolving branch
- SignExt  in  ADDR_W  sign-extended word offset

## Operation
- States: IDLE, REQ, WAIT, HOLD. A Discard flag qualifies WAIT.
- Taken redirect: BrValid & Branch & ALUZero. It loads PC <= BranchPC + (SignExt << 2), computed mod 2^64. The shift result is truncated to ADDR_W.
- IDLE
  - Halt=0 -> REQ.
  - A taken redirect updates PC and does not change state.
- REQ
  - IMemReq=1 and IMemAddr=PC.
  - IMemGnt -> WAIT with Discard=0.
  - Redirect without Gnt: PC updates and the state stays REQ. IMemAddr may change while the request is ungranted.
  - Redirect with Gnt in the same cycle: PC updates, and the next state is WAIT with Discard=1.
- WAIT
  - IMemRspValid with Discard=0: Instr <= IMemRspData, InstrPC <= PC, PC <= PC+4, -> HOLD.
  - IMemRspValid with Discard=1: drop the data, clear Discard, -> REQ.
  - Redirect while waiting: PC updates and Discard is set. If the redirect coincides with a valid response, that response is dropped and the state goes to REQ.
- HOLD
  - InstrValid=1.
  - InstrReady -> IDLE if Halt=1, otherwise REQ.
  - A redirect drops the held instruction (InstrValid=0 next cycle), updates PC, and goes to REQ.
  - If a redirect and InstrReady occur in the same cycle, the redirect wins. The instruction counts as consumed.
- PC+4 wraps modulo 2^64.
- The block performs no alignment check.
- IMemRspValid is ignored outside WAIT.

## Timing
- Reset (Rst=0, asynchronous):
  - state=IDLE, PC=RESET_PC, Discard=0
  - IMemReq=0, IMemAddr=RESET_PC
  - InstrValid=0, Instr=0, InstrPC=0
- Reset asserted mid-operation aborts any in-flight fetch immediately. A late response after reset is ignored because the state is not WAIT.
- Minimum fetch latency, from REQ entry to InstrValid, is 2 cycles:
  - REQ with Gnt
  - WAIT with response
  - HOLD
- Memory returns its response no earlier than the cycle after Gnt.
- Redirect-to-request: IMemAddr shows the target the cycle after the redirect.
- Throughput: at most one instruction per 3 cycles, since HOLD must exit before the next REQ.
- Outputs are registered or decoded from registered state. There is no combinational path from inputs to IMemReq or InstrValid.

## Structure
- Shared package (fetch_pkg):
  - state enum (IDLE, REQ, WAIT, HOLD)
  - ADDR_W, INSTR_W, PC_INCR=4, BR_SHIFT=2
- Sub-module pc_target_adder: combinational BranchPC + (SignExt << BR_SHIFT), plus the PC + PC_INCR incrementer. It is shared with datapath branch logic.

## Test plan
- Reset release with RESET_PC=0, Halt=0, Gnt tied 1, response one cycle after Gnt, InstrReady=1 -> IMemAddr sequence 0, 4, 8, each presented with matching InstrPC.
- Fetch of PC=0x10 followed by a redirect in WAIT with BranchPC=0x10 and SignExt=3 -> the response for 0x10 is dropped, the next IMemAddr is 0x1C, and InstrValid is never asserted for 0x10.
- Redirect in HOLD with SignExt=-2 (0xFFFF_FFFF_FFFF_FFFE) and BranchPC=0x20 -> InstrValid drops, and the next IMemAddr is 0x18.
- PC=0xFFFF_FFFF_FFFF_FFFC fetched -> the next IMemAddr is 0x0 (wrap).
- Gnt held low for 5 cycles, with a redirect in cycle 2 -> IMemAddr switches to the target while IMemReq stays 1, and only the target is granted.
- Rst asserted during WAIT, then a response arrives -> outputs return to reset values and the response is ignored. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch sequencer and the branch
// target arithmetic it shares with the datapath.
//   ADDR_W   : PC / memory address width
//   INSTR_W  : instruction width
//   PC_INCR  : sequential PC step in bytes
//   BR_SHIFT : word-offset to byte-offset shift for CBZ targets
//   fetch_state_e : fetch sequencer states
package fetch_pkg;

  localparam int ADDR_W   = 64;
  localparam int INSTR_W  = 32;
  localparam int PC_INCR  = 4;
  localparam int BR_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_target_adder.sv
// pc_target_adder
// Combinational PC arithmetic: the CBZ target BranchPC + (SignExt << 2) and
// the sequential PC + 4. Both wrap modulo 2^W; the shifted offset is
// truncated to W bits before the add.
// Ports:
//   i_BranchPC  in  W  PC of the resolving branch
//   i_SignExt   in  W  sign-extended word offset
//   i_PC        in  W  current PC
//   o_Target    out W  branch target
//   o_PCPlus4   out W  next sequential PC
module pc_target_adder #(
  parameter int W = fetch_pkg::ADDR_W
) (
  input  logic [W-1:0] i_BranchPC,
  input  logic [W-1:0] i_SignExt,
  input  logic [W-1:0] i_PC,
  output logic [W-1:0] o_Target,
  output logic [W-1:0] o_PCPlus4
);
  import fetch_pkg::*;

  logic [W-1:0] w_ByteOffset;

  assign w_ByteOffset = i_SignExt << BR_SHIFT;
  assign o_Target     = i_BranchPC + w_ByteOffset;
  assign o_PCPlus4    = i_PC + W'(PC_INCR);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the PC and sequences instruction fetch: one outstanding request to
// instruction memory (req/gnt, then a response), and the returned instruction
// is held for decode (valid/ready). A taken CBZ redirects the PC; any fetch
// already granted when the redirect happens is marked for discard.
// Ports:
//   i_Clk           in   1        clock, rising edge
//   i_Rst           in   1        asynchronous reset, active low
//   i_Halt          in   1        suppress new fetches (IDLE / HOLD exits)
//   o_IMemReq       out  1        fetch request
//   o_IMemAddr      out  ADDR_W   fetch address (current PC)
//   i_IMemGnt       in   1        request accepted
//   i_IMemRspValid  in   1        response valid
//   i_IMemRspData   in   INSTR_W  fetched instruction
//   o_InstrValid    out  1        instruction available to decode
//   o_Instr         out  INSTR_W  held instruction
//   o_InstrPC       out  ADDR_W   address of o_Instr
//   i_InstrReady    in   1        decode accepts o_Instr
//   i_BrValid       in   1        branch resolution valid
//   i_Branch        in   1        resolving instruction is CBZ
//   i_ALUZero       in   1        compare result zero
//   i_BranchPC      in   ADDR_W   PC of the resolving branch
//   i_SignExt       in   ADDR_W   sign-extended word offset
module fetch_sequencer #(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Halt,
  output logic               o_IMemReq,
  output logic [ADDR_W-1:0]  o_IMemAddr,
  input  logic               i_IMemGnt,
  input  logic               i_IMemRspValid,
  input  logic [INSTR_W-1:0] i_IMemRspData,
  output logic               o_InstrValid,
  output logic [INSTR_W-1:0] o_Instr,
  output logic [ADDR_W-1:0]  o_InstrPC,
  input  logic               i_InstrReady,
  input  logic               i_BrValid,
  input  logic               i_Branch,
  input  logic               i_ALUZero,
  input  logic [ADDR_W-1:0]  i_BranchPC,
  input  logic [ADDR_W-1:0]  i_SignExt
);
  import fetch_pkg::*;

  fetch_state_e        r_State;
  logic [ADDR_W-1:0]   r_PC;
  logic                r_Discard;
  logic                r_IMemReq;
  logic                r_InstrValid;
  logic [INSTR_W-1:0]  r_Instr;
  logic [ADDR_W-1:0]   r_InstrPC;

  logic                w_Redirect;
  logic [ADDR_W-1:0]   w_Target;
  logic [ADDR_W-1:0]   w_PCPlus4;

  assign w_Redirect = i_BrValid & i_Branch & i_ALUZero;

  pc_target_adder #(
    .W (ADDR_W)
  ) u_pc_target_adder (
    .i_BranchPC (i_BranchPC),
    .i_SignExt  (i_SignExt),
    .i_PC       (r_PC),
    .o_Target   (w_Target),
    .o_PCPlus4  (w_PCPlus4)
  );

  // r_IMemReq / r_InstrValid are set alongside every state change so they
  // always equal (state == REQ) / (state == HOLD) without input-to-output paths.
  // r_Discard marks a granted fetch whose address was superseded by a redirect;
  // its response is swallowed and the fetch is reissued at the new PC.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State      <= IDLE;
      r_PC         <= RESET_PC;
      r_Discard    <= 1'b0;
      r_IMemReq    <= 1'b0;
      r_InstrValid <= 1'b0;
      r_Instr      <= '0;
      r_InstrPC    <= '0;
    end else begin
      case (r_State)
        IDLE: begin
          if (w_Redirect) begin
            r_PC <= w_Target;
          end
          if (!i_Halt) begin
            r_State   <= REQ;
            r_IMemReq <= 1'b1;
          end
        end

        REQ: begin
          if (w_Redirect) begin
            r_PC <= w_Target;
          end
          if (i_IMemGnt) begin
            r_State   <= WAIT;
            r_IMemReq <= 1'b0;
            r_Discard <= w_Redirect;
          end
        end

        WAIT: begin
          if (w_Redirect) begin
            r_PC <= w_Target;
            if (i_IMemRspValid) begin
              r_State   <= REQ;
              r_IMemReq <= 1'b1;
              r_Discard <= 1'b0;
            end else begin
              r_Discard <= 1'b1;
            end
          end else if (i_IMemRspValid) begin
            r_Discard <= 1'b0;
            if (r_Discard) begin
              r_State   <= REQ;
              r_IMemReq <= 1'b1;
            end else begin
              r_Instr      <= i_IMemRspData;
              r_InstrPC    <= r_PC;
              r_PC         <= w_PCPlus4;
              r_State      <= HOLD;
              r_InstrValid <= 1'b1;
            end
          end
        end

        HOLD: begin
          // A redirect wins over a simultaneous InstrReady.
          if (w_Redirect) begin
            r_PC         <= w_Target;
            r_InstrValid <= 1'b0;
            r_State      <= REQ;
            r_IMemReq    <= 1'b1;
          end else if (i_InstrReady) begin
            r_InstrValid <= 1'b0;
            if (i_Halt) begin
              r_State <= IDLE;
            end else begin
              r_State   <= REQ;
              r_IMemReq <= 1'b1;
            end
          end
        end

        default: begin
          r_State      <= IDLE;
          r_IMemReq    <= 1'b0;
          r_InstrValid <= 1'b0;
          r_Discard    <= 1'b0;
        end
      endcase
    end
  end

  assign o_IMemReq    = r_IMemReq;
  assign o_IMemAddr   = r_PC;
  assign o_InstrValid = r_InstrValid;
  assign o_Instr      = r_Instr;
  assign o_InstrPC    = r_InstrPC;

endmodule
